// File: rtl/wb_grf.sv
// Write-back stage and 32-entry GPR file: selects the write-back value, commits it,
// serves two D-stage read ports with W->D bypass, and keeps a retire log/counter.
module wb_grf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] W_AO,
    input  logic [DATA_W-1:0] W_DR,
    input  logic [31:0]       W_pc,
    input  logic [31:0]       W_pc8,
    input  logic [1:0]        SelWout_W,
    input  logic [4:0]        W_A3,
    input  logic              RegWrite_W,
    input  logic [4:0]        D_A1,
    input  logic [4:0]        D_A2,
    output logic [DATA_W-1:0] D_RD1,
    output logic [DATA_W-1:0] D_RD2,
    output logic [DATA_W-1:0] W_WD,
    output logic              wb_valid,
    output logic [31:0]       wb_pc,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic [DATA_W-1:0] r_grf [32];
    logic              r_wb_valid;
    logic [31:0]       r_wb_pc;
    logic [4:0]        r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic [CNT_W-1:0]  r_retire_cnt;

    logic [DATA_W-1:0] w_wd;
    logic              w_we;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // W_pc8 is 32 bits; it is resized to the data width for the link value.
    always_comb begin
        w_wd = '0;
        unique case (SelWout_W)
            2'd0:    w_wd = W_AO;
            2'd1:    w_wd = W_DR;
            2'd2:    w_wd = DATA_W'(W_pc8);
            default: w_wd = '0;
        endcase
    end

    // A write in a reset cycle or to $zero never commits.
    assign w_we = RegWrite_W && (W_A3 != 5'd0) && reset;

    always_comb begin
        w_rd1 = '0;
        if (D_A1 == 5'd0) begin
            w_rd1 = '0;
        end else if (w_we && (D_A1 == W_A3)) begin
            w_rd1 = w_wd;
        end else begin
            w_rd1 = r_grf[D_A1];
        end
    end

    always_comb begin
        w_rd2 = '0;
        if (D_A2 == 5'd0) begin
            w_rd2 = '0;
        end else if (w_we && (D_A2 == W_A3)) begin
            w_rd2 = w_wd;
        end else begin
            w_rd2 = r_grf[D_A2];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_grf[i] <= '0;
            end
        end else if (w_we) begin
            r_grf[W_A3] <= w_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wb_valid   <= 1'b0;
            r_wb_pc      <= '0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_wb_valid <= w_we;
            if (w_we) begin
                r_wb_pc      <= W_pc;
                r_wb_addr    <= W_A3;
                r_wb_data    <= w_wd;
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    assign W_WD       = w_wd;
    assign D_RD1      = w_rd1;
    assign D_RD2      = w_rd2;
    assign wb_valid   = r_wb_valid;
    assign wb_pc      = r_wb_pc;
    assign wb_addr    = r_wb_addr;
    assign wb_data    = r_wb_data;
    assign retire_cnt = r_retire_cnt;

endmodule
